// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   RV32I execute stage. Takes a 4-bit ALU control code and two operands and
//   returns a registered result. Valid/ready handshakes are used on both sides.
//   ADD/SUB/logic/compare and illegal codes finish on the accept edge. SLL/SRL/SRA
//   use an iterative shifter that moves one bit per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of any in-flight operation
//   in_valid   ALU_Ctrl/op_a/op_b are valid
//   in_ready   unit can accept a new operation (IDLE)
//   ALU_Ctrl   operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT,
//              6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10-15 illegal
//   op_a       operand A (rs1)
//   op_b       operand B (rs2 or immediate); the shift amount is op_b[SHAMT_W-1:0]
//   out_valid  result/zero/illegal are valid (DONE)
//   out_ready  consumer accepts the result
//   result     registered result
//   zero       result == 0
//   illegal    ALU_Ctrl was an unused code
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        ALU_Ctrl,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic              zero,
   output logic              illegal
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q;
   logic [XLEN-1:0]      shift_q, shift_next;
   logic [SHAMT_W-1:0]   cnt_q;
   logic [XLEN-1:0]      result_q;
   logic                 zero_q, illegal_q;

   logic [XLEN-1:0]      alu_res;
   logic                 alu_illegal;
   logic                 is_shift;
   logic [SHAMT_W-1:0]   shamt;
   logic                 load_result, start_shift, step_shift;

   assign shamt    = op_b[SHAMT_W-1:0];
   assign is_shift = (ALU_Ctrl == OP_SLL) || (ALU_Ctrl == OP_SRL) || (ALU_Ctrl == OP_SRA);

   // Single-cycle datapath, evaluated on the live inputs at the accept edge.
   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      alu_res     = '0;
      alu_illegal = 1'b0;
      case (ALU_Ctrl)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         // A shift only takes this path when its amount is zero.
         OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
         default: alu_illegal = 1'b1;
      endcase
   end

   // One-bit step of the iterative shifter; any non-SLL/SRL code here is SRA.
   always_comb begin
      case (op_q)
         OP_SLL:  shift_next = {shift_q[XLEN-2:0], 1'b0};
         OP_SRL:  shift_next = {1'b0, shift_q[XLEN-1:1]};
         default: shift_next = {shift_q[XLEN-1], shift_q[XLEN-1:1]};
      endcase
   end

   // Next-state and handshake decode. flush overrides everything, including
   // the datapath load enables, so an aborted op leaves no trace.
   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      load_result = 1'b0;
      start_shift = 1'b0;
      step_shift  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_shift && (shamt != '0)) begin
                  start_shift = 1'b1;
                  state_d     = SHIFT;
               end else begin
                  load_result = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         SHIFT: begin
            step_shift = 1'b1;
            if (cnt_q == SHAMT_W'(1)) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d     = IDLE;
         load_result = 1'b0;
         start_shift = 1'b0;
         step_shift  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the datapath registers are reset too, because result/zero/illegal
         // are architecturally visible and must read zero out of reset.
         state_q   <= IDLE;
         op_q      <= OP_ADD;
         shift_q   <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_result) begin
            result_q  <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= alu_illegal;
         end
         if (start_shift) begin
            op_q    <= ALU_Ctrl;
            shift_q <= op_a;
            cnt_q   <= shamt;
         end
         if (step_shift) begin
            shift_q <= shift_next;
            cnt_q   <= cnt_q - SHAMT_W'(1);
            // The last step publishes the shifted value directly.
            if (cnt_q == SHAMT_W'(1)) begin
               result_q  <= shift_next;
               zero_q    <= (shift_next == '0);
               illegal_q <= 1'b0;
            end
         end
      end
   end

   assign result  = result_q;
   assign zero    = zero_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Directed and randomized checks of alu_exec_unit against an arithmetic
//   reference model. Latency is counted in rising edges after the accept edge.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] op_a, op_b, result;
   logic        out_valid, out_ready, zero, illegal;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALU_Ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   // Reference model: {illegal, result}.
   function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      int unsigned        sh;
      logic signed [31:0] sa;
      sh = b[4:0];
      sa = a;
      case (c)
         4'd0:    return {1'b0, a + b};
         4'd1:    return {1'b0, a - b};
         4'd2:    return {1'b0, a & b};
         4'd3:    return {1'b0, a | b};
         4'd4:    return {1'b0, a ^ b};
         4'd5:    return {1'b0, 31'd0, ($signed(a) < $signed(b))};
         4'd6:    return {1'b0, 31'd0, (a < b)};
         4'd7:    return {1'b0, a << sh};
         4'd8:    return {1'b0, a >> sh};
         4'd9:    return {1'b0, sa >>> sh};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op, wait for out_valid, hold the result for `hold` cycles, then drain.
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
      logic [32:0] m;
      int          exp_lat, lat;
      m       = model(c, a, b);
      exp_lat = ((c inside {4'd7, 4'd8, 4'd9}) && (b[4:0] != 5'd0)) ? int'(b[4:0]) : 0;
      @(negedge clk);
      check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      // Scramble the inputs: the op must already be captured.
      in_valid = 1'b0;
      alu_ctrl = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"}, result, m[31:0]);
      check({tag, "_zero"}, 32'(zero), 32'(m[31:0] == 32'd0));
      check({tag, "_illegal"}, 32'(illegal), 32'(m[32]));
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_held_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_held_result"}, result, m[31:0]);
         check({tag, "_held_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_drained_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_drained_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic saw_valid;
      logic [3:0] rc;

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_ctrl  = 4'd0;
      op_a      = 32'd0;
      op_b      = 32'd0;

      // Reset state.
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed single-cycle and boundary cases.
      run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_wrap");
      run_op(4'd1, 32'h0000_0005, 32'h0000_0005, 1, "sub_zero");
      run_op(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0, "slt");
      run_op(4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 0, "sltu");
      run_op(4'd9, 32'h8000_0000, 32'h0000_003F, 0, "sra31");
      run_op(4'd7, 32'h1234_5678, 32'h0000_0000, 0, "sll0");
      run_op(4'd12, 32'hDEAD_BEEF, 32'h1234_5678, 0, "illegal12");
      run_op(4'd3, 32'h0000_00F0, 32'h0000_000F, 5, "or_backpressure");

      // Reset in the middle of an SRL by 20.
      @(negedge clk);
      alu_ctrl = 4'd8;
      op_a     = 32'hF0F0_1234;
      op_b     = 32'd20;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_zero", 32'(zero), 32'd0);
      check("midrst_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'd0, 32'd2, 32'd3, 0, "add_after_rst");

      // Flush at the third edge of an SLL by 10: no result may appear.
      @(negedge clk);
      alu_ctrl = 4'd7;
      op_a     = 32'h0000_0ABC;
      op_b     = 32'd10;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      saw_valid = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("flush_no_valid", 32'(saw_valid), 32'd0);
      check("flush_in_ready", 32'(in_ready), 32'd1);

      // Randomized ops with random backpressure.
      for (int i = 0; i < 40; i++) begin
         rc = 4'($urandom_range(0, 15));
         run_op(rc, $urandom, $urandom, int'($urandom_range(0, 3)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
